// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, even parity, stop bit.
// Result one clock after the stop-sample strobe. No backpressure: pacing comes only from bit_en.
module parity_frame_rx #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rxd,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RECOVER} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [BC_W-1:0]   bitcnt;
    logic              par_run;
    logic              last_bit;

    assign last_bit = (bitcnt == BC_W'(DATA_W - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!rxd) state_nxt = DATA;
                DATA:    if (last_bit) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = rxd ? IDLE : RECOVER;
                // A held-low line must return high before a new start bit counts
                RECOVER: if (rxd) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            par_run  <= 1'b0;
            data_out <= '0;
            valid    <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!rxd) begin
                            bitcnt  <= '0;
                            shreg   <= '0;
                            par_run <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg[bitcnt] <= rxd;
                        par_run       <= par_run ^ rxd;
                        if (!last_bit) bitcnt <= bitcnt + 1'b1;
                    end
                    PARITY: par_run <= par_run ^ rxd;
                    STOP: begin
                        data_out <= shreg;
                        par_err  <= par_run;
                        frm_err  <= ~rxd;
                        valid    <= 1'b1;
                        if (par_run && (err_cnt != {CNT_W{1'b1}}))
                            err_cnt <= err_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receiver and checker that sits directly downstream of the 4-bit parity generator.
- Accepts a framed serial stream on one line: start bit, DATA_W data bits, even-parity bit, stop bit.
- Recovers the data word, flags parity and framing errors, and keeps a saturating count of parity errors.
- Bit timing comes from an external one-cycle strobe, so the block is baud-agnostic.

Parameters:
- DATA_W, 4, number of data bits per frame; range 1..16.
- CNT_W, 8, width of the parity-error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  sample strobe; rxd is sampled only on edges where bit_en=1.
- rxd  input  1  serial line; idle level 1.
- data_out  output  DATA_W  last received word; first received bit lands in data_out[0] (LSB first).
- valid  output  1  one-cycle pulse: frame complete, data_out and flags updated.
- par_err  output  1  parity result of the last frame; 1 = XOR of data and parity bit is 1.
- frm_err  output  1  stop bit of the last frame was sampled as 0.
- busy  output  1  high while in DATA, PARITY, STOP or RECOVER.
- err_cnt  output  CNT_W  number of frames with par_err=1, saturating.

Behaviour:
- Reset (rst=1 at a rising edge) has top priority and applies mid-frame:
  - state=IDLE; data_out=0, valid=0, par_err=0, frm_err=0, busy=0, err_cnt=0.
  - shift register and bit counter are cleared; a partial frame is discarded with no valid.
- Parity convention: even. The parity bit equals the XOR of the data bits, so a correct frame has XOR(data, parity)=0.
- All state transitions happen only on edges with bit_en=1. With bit_en=0, state, counters and the shift register hold.
- IDLE:
  - bit_en and rxd=0 -> DATA, bit counter=0.
  - bit_en and rxd=1 -> stay in IDLE.
- DATA:
  - each bit_en shifts rxd into the next data position, in bit-counter order.
  - the running parity is XORed with rxd.
  - when bit counter=DATA_W-1, go to PARITY; otherwise increment the counter.
- PARITY: on bit_en, XOR rxd into the running parity -> STOP.
- STOP: on bit_en, on that same edge:
  - data_out <= assembled word; par_err <= running parity; frm_err <= ~rxd; valid <= 1.
  - err_cnt increments if the running parity is 1, saturating at 2^CNT_W-1 (no wrap).
  - rxd=1 -> IDLE; rxd=0 -> RECOVER.
- RECOVER (line stuck low / break): on bit_en with rxd=1 -> IDLE. A start bit is never accepted directly from RECOVER.
- valid:
  - high for exactly one clock after the stop-sample edge, then returns to 0 on the next edge regardless of bit_en.
  - not asserted in any other case.
- data_out, par_err and frm_err hold their values between frames.
- busy is combinational from state: 0 in IDLE, 1 in all other states.
- Back-to-back frames: a start bit on the very next bit_en after a good stop bit is accepted (STOP -> IDLE -> DATA on consecutive strobes).
- Minimum frame: DATA_W+3 strobes.

Test Plan:
- Good frame, DATA_W=4, rxd per strobe 0,1,1,0,1,1,1 (data 4'b1011, parity 1) -> one valid pulse, data_out=4'hB, par_err=0, frm_err=0, err_cnt=0.
- Parity error: same frame with parity bit 0 -> valid, data_out=4'hB, par_err=1, err_cnt=1.
- Framing error: data 4'h5, parity 0, stop bit 0, then rxd held 0 for 3 strobes, then 1, then a good frame for 4'h3 -> first valid with frm_err=1, no frame started while low, second valid with data_out=4'h3, frm_err=0.
- Gaps: insert 0-5 idle cycles (bit_en=0) between strobes of a good 4'hA frame -> same result as with no gaps; valid exactly one cycle wide.
- Reset mid-frame: assert rst after the 2nd data bit, then send a good 4'h6 frame -> no valid for the aborted frame, outputs 0 after reset, then data_out=4'h6.
- Saturation: CNT_W=2, send 5 parity-error frames -> err_cnt sequence 1,2,3,3,3.
